uvmt_cv32e40s_obi_mem_responder: RTL



---
 rtl/uvmt_cv32e40s_obi_mem_responder_if.sv | 29 ++
 rtl/uvmt_cv32e40s_obi_mem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uvmt_cv32e40s_obi_mem_responder_if.sv
// OBI bus bundle between a cv32e40s port and its memory responder.
// Signal names keep the core-side _i/_o directions of the responder.
interface uvmt_cv32e40s_obi_mem_responder_if;
  logic        req_i;
  logic        reqpar_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        gntpar_o;
  logic        rvalid_o;
  logic        rvalidpar_o;
  logic [31:0] rdata_o;
  logic [4:0]  rchk_o;
  logic        err_o;

  modport master (
    output req_i, reqpar_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, gntpar_o, rvalid_o, rvalidpar_o,
    input  rdata_o, rchk_o, err_o
  );

  modport slave (
    input  req_i, reqpar_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, gntpar_o, rvalid_o, rvalidpar_o,
    output rdata_o, rchk_o, err_o
  );
endinterface

// File: rtl/uvmt_cv32e40s_obi_mem_responder.sv
// OBI slave memory with grant stall, fixed-latency in-order responses,
// error injection and request-parity monitoring.
module uvmt_cv32e40s_obi_mem_responder #(
  parameter int MEM_WORDS_LOG2   = 10,
  parameter int MAX_OUTSTANDING  = 2,
  parameter int RVALID_LATENCY   = 1,
  parameter int GNT_STALL_CYCLES = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  uvmt_cv32e40s_obi_mem_responder_if.slave bus,
  input  logic       stall_en_i,
  input  logic       err_inject_i,
  output logic       integrity_err_o,
  output logic [2:0] outstanding_o
);
  localparam int DEPTH = MAX_OUTSTANDING;
  localparam int QW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW =
    (RVALID_LATENCY > 1) ? $clog2(RVALID_LATENCY) : 1;
  localparam int WL = MEM_WORDS_LOG2;
  localparam bit DIRECT = (RVALID_LATENCY == 1);
  localparam logic [3:0] STALL_N = 4'(GNT_STALL_CYCLES);
  localparam logic [2:0] MAX_N = 3'(MAX_OUTSTANDING);
  localparam logic [AW-1:0] POP_AGE = AW'(RVALID_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, STALL, READY} stall_e;

  stall_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic stall_active, stall_done;
  logic gnt, accept;

  logic [WL-1:0] idx;
  logic addr_err, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] mem [2**WL];

  logic          q_vld  [DEPTH];
  logic          q_err  [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [AW-1:0] q_age  [DEPTH];
  logic [QW-1:0] wr_q, rd_q;
  logic push, pop, fire;

  logic        rvalid_q, err_q;
  logic [31:0] rdata_q;
  logic [4:0]  rchk;
  logic [2:0]  outst_q;
  logic        integ_q;

  function automatic logic [QW-1:0] nxt(input logic [QW-1:0] p);
    return (p == QW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign stall_active = stall_en_i && (GNT_STALL_CYCLES != 0);
  assign stall_done = !stall_active || (state_q == READY);
  assign gnt = bus.req_i && (outst_q < MAX_N) && stall_done;
  assign accept = bus.req_i && gnt;
  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!stall_active) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.req_i) begin
          cnt_d   = 4'd1;
          state_d = (STALL_N == 4'd1) ? READY : STALL;
        end
        STALL: if (!bus.req_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == STALL_N) state_d = READY;
        end
        READY: if (accept) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idx = bus.addr_i[WL+1:2];
  assign addr_err = |bus.addr_i[31:WL+2];
  assign rsp_err = addr_err || err_inject_i;
  assign rsp_data = (bus.we_i || rsp_err) ? '0 : mem[idx];

  always_ff @(posedge clk_i) begin
    if (accept && bus.we_i && !rsp_err) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.be_i[b]) mem[idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
      end
    end
  end

  // Latency 1 answers straight from the acceptance cycle; longer
  // latencies park the response here until its age matures.
  assign push = accept && !DIRECT;
  assign pop = q_vld[rd_q] && (q_age[rd_q] == POP_AGE);
  assign fire = DIRECT ? accept : pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_vld[i]  <= 1'b0;
        q_err[i]  <= 1'b0;
        q_data[i] <= '0;
        q_age[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_vld[i]) q_age[i] <= q_age[i] + 1'b1;
      end
      if (pop) begin
        q_vld[rd_q] <= 1'b0;
        rd_q        <= nxt(rd_q);
      end
      if (push) begin
        q_vld[wr_q]  <= 1'b1;
        q_err[wr_q]  <= rsp_err;
        q_data[wr_q] <= rsp_data;
        q_age[wr_q]  <= AW'(1);
        wr_q         <= nxt(wr_q);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= fire;
      if (fire) begin
        rdata_q <= DIRECT ? rsp_data : q_data[rd_q];
        err_q   <= DIRECT ? rsp_err : q_err[rd_q];
      end
    end
  end

  // A retiring response frees its slot only after its rvalid cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_q <= '0;
    end else begin
      case ({accept, rvalid_q})
        2'b10:   outst_q <= outst_q + 3'd1;
        2'b01:   outst_q <= outst_q - 3'd1;
        default: outst_q <= outst_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      integ_q <= 1'b0;
    end else if (bus.reqpar_i == bus.req_i) begin
      integ_q <= 1'b1;
    end
  end

  always_comb begin
    rchk = {err_q, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      rchk[i] = ^rdata_q[8*i +: 8];
    end
  end

  assign bus.gnt_o       = gnt;
  assign bus.gntpar_o    = ~gnt;
  assign bus.rvalid_o    = rvalid_q;
  assign bus.rvalidpar_o = ~rvalid_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.err_o       = err_q;
  assign bus.rchk_o      = rchk;
  assign integrity_err_o = integ_q;
  assign outstanding_o   = outst_q;
endmodule
